// File: rtl/tt_sweep_checker_pkg.sv
// tt_sweep_pkg: shared state type, size limits and truth-table helpers for the sweep checker
package tt_sweep_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} tt_state_e;
    localparam int N_IN_DEF = 7;
    localparam int N_IN_MAX = 10;
    localparam int TT_W_MAX = 1 << N_IN_MAX;
    localparam int WAIT_W = 4;
    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction
    function automatic logic tt_bit(input logic [TT_W_MAX-1:0] tt, input logic [N_IN_MAX-1:0] idx);
        return tt[idx];
    endfunction
endpackage

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: drives every input vector to a netlist, captures y0 and compares against a golden table
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int SETTLE = 0,
    localparam int TT_W = tt_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [TT_W-1:0] exp_tt_i,
    output logic [N_IN-1:0] x_out_o,
    input  logic            y_in_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [TT_W-1:0] obs_tt_o,
    output logic [N_IN:0]   mismatch_cnt_o,
    output logic            first_err_valid_o,
    output logic [N_IN-1:0] first_err_idx_o,
    output logic            pass_o
);
    tt_state_e state_q, state_d;
    logic [TT_W-1:0] exp_q, obs_q;
    logic [N_IN-1:0] idx_q, first_idx_q;
    logic [WAIT_W-1:0] wait_q;
    logic [N_IN:0] cnt_q;
    logic fev_q, done_seen_q, last, mis;

    assign last = &idx_q;
    assign mis = y_in_i != tt_bit(TT_W_MAX'(exp_q), N_IN_MAX'(idx_q));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SETTLE > 0 ? HOLD : SAMPLE;
            HOLD:    if (int'(wait_q) == SETTLE - 1) state_d = SAMPLE;
            SAMPLE:  state_d = last ? DONE : (SETTLE > 0 ? HOLD : SAMPLE);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q == HOLD || state_q == SAMPLE;
        done_o = state_q == DONE;
    end

    // done_seen is set on the final sample so pass is already valid during the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= '0;
            obs_q       <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            cnt_q       <= '0;
            first_idx_q <= '0;
            fev_q       <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    exp_q       <= exp_tt_i;
                    obs_q       <= '0;
                    idx_q       <= '0;
                    wait_q      <= '0;
                    cnt_q       <= '0;
                    first_idx_q <= '0;
                    fev_q       <= 1'b0;
                    done_seen_q <= 1'b0;
                end
                HOLD: wait_q <= wait_q + WAIT_W'(1);
                SAMPLE: begin
                    obs_q[idx_q] <= y_in_i;
                    wait_q <= '0;
                    if (mis) cnt_q <= cnt_q + (N_IN+1)'(1);
                    if (mis && !fev_q) begin
                        first_idx_q <= idx_q;
                        fev_q       <= 1'b1;
                    end
                    if (last) done_seen_q <= 1'b1;
                    else idx_q <= idx_q + N_IN'(1);
                end
                default: ;
            endcase
        end
    end

    assign x_out_o           = idx_q;
    assign obs_tt_o          = obs_q;
    assign mismatch_cnt_o    = cnt_q;
    assign first_err_valid_o = fev_q;
    assign first_err_idx_o   = first_idx_q;
    assign pass_o            = done_seen_q & (cnt_q == '0);
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: two checkers (settle 0 and 3) against a cycle-level behavioural model
module tb_tt_sweep_checker;
    localparam int N = 7;
    localparam int TW = 128;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [TW-1:0] exp_tt = '0, net_tt = '0, g, e;
    logic [N-1:0] x_o[2], fei_o[2];
    logic [N-1:0] xd1 = '0, xd2 = '0, xd3 = '0;
    logic busy_o[2], done_o[2], fev_o[2], pass_o[2], y[2];
    logic [TW-1:0] obs_o[2];
    logic [N:0] cnt_o[2];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    tt_sweep_checker #(.N_IN(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .exp_tt_i(exp_tt), .x_out_o(x_o[0]), .y_in_i(y[0]),
        .busy_o(busy_o[0]), .done_o(done_o[0]), .obs_tt_o(obs_o[0]), .mismatch_cnt_o(cnt_o[0]),
        .first_err_valid_o(fev_o[0]), .first_err_idx_o(fei_o[0]), .pass_o(pass_o[0]));

    tt_sweep_checker #(.N_IN(N), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start_i(start), .exp_tt_i(exp_tt), .x_out_o(x_o[1]), .y_in_i(y[1]),
        .busy_o(busy_o[1]), .done_o(done_o[1]), .obs_tt_o(obs_o[1]), .mismatch_cnt_o(cnt_o[1]),
        .first_err_valid_o(fev_o[1]), .first_err_idx_o(fei_o[1]), .pass_o(pass_o[1]));

    // netlists: instant for dut0, output lags x_out by three cycles for dut3
    assign y[0] = net_tt[x_o[0]];
    always @(posedge clk) begin
        xd1 <= x_o[1];
        xd2 <= xd1;
        xd3 <= xd2;
    end
    assign y[1] = net_tt[xd3];

    function automatic int per(input int d);
        return d == 0 ? 1 : 4;
    endfunction

    bit started[2];
    int k[2];
    logic [TW-1:0] m_exp[2], m_net[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) started[d] = 1'b0;
            else if (start && (!started[d] || k[d] > TW * per(d))) begin
                started[d] = 1'b1;
                k[d] = 0;
                m_exp[d] = exp_tt;
                m_net[d] = net_tt;
            end else if (started[d] && k[d] <= TW * per(d)) k[d]++;
        end
    end

    function automatic logic [153:0] model(input int d);
        int p = per(d), n = 0, cnt = 0, fe = 0;
        logic [TW-1:0] obs = '0;
        logic [N-1:0] x = '0;
        bit b = 0, dn = 0, ps = 0;
        if (started[d]) begin
            n = k[d] / p;
            if (n > TW) n = TW;
            x = N'(n < TW ? n : TW - 1);
            b = n < TW;
            dn = k[d] == TW * p;
            for (int i = 0; i < n; i++) begin
                obs[i] = m_net[d][i];
                if (m_net[d][i] != m_exp[d][i]) begin
                    if (cnt == 0) fe = i;
                    cnt++;
                end
            end
            ps = k[d] >= TW * p && cnt == 0;
        end
        return {x, b, dn, obs, 8'(cnt), cnt != 0, N'(fe), ps};
    endfunction

    function automatic logic [153:0] actual(input int d);
        return {x_o[d], busy_o[d], done_o[d], obs_o[d], cnt_o[d], fev_o[d], fei_o[d], pass_o[d]};
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (actual(d) !== model(d)) begin
                errors++;
                $display("FAIL cycle_cmp dut%0d t=%0t got=%h exp=%h", d, $time, actual(d), model(d));
            end
        end
    end

    int run = 0;
    logic [N-1:0] px = '0;
    bit pb = 0, hold_chk = 0;
    always @(negedge clk) begin
        if (hold_chk && pb && (!busy_o[1] || x_o[1] != px)) begin
            checks++;
            if (run != 4) begin
                errors++;
                $display("FAIL hold_len x=%0d got=%0d exp=4", px, run);
            end
        end
        run = (busy_o[1] && pb && x_o[1] == px) ? run + 1 : 1;
        px = x_o[1];
        pb = busy_o[1];
    end

    task automatic chkv(input string nm, input logic [159:0] a, input logic [159:0] ex);
        checks++;
        if (a !== ex) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, a, ex);
        end
    endtask

    task automatic chki(input string nm, input int a, input int ex);
        checks++;
        if (a != ex) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, a, ex);
        end
    endtask

    task automatic sweep(input int pulse_at, input int rst_at, input bit scramble);
        int nd0 = 0, nd3 = 0, t0 = 0, t3 = 0;
        @(negedge clk) start = 1'b1;
        for (int i = 1; i <= 530; i++) begin
            @(negedge clk);
            start = i == pulse_at;
            rst = i == rst_at;
            if (scramble && i == 5) exp_tt = {$urandom, $urandom, $urandom, $urandom};
            if (rst_at > 0 && i == rst_at + 1) begin
                chkv("reset_mid_s0", 160'(actual(0)), '0);
                chkv("reset_mid_s3", 160'(actual(1)), '0);
            end
            if (done_o[0]) begin nd0++; t0 = i; end
            if (done_o[1]) begin nd3++; t3 = i; end
        end
        if (rst_at == 0) begin
            chki("done_lat_s0", t0, 129);
            chki("done_lat_s3", t3, 513);
            chki("done_cnt_s0", nd0, 1);
            chki("done_cnt_s3", nd3, 1);
        end else begin
            chki("no_done_s0", nd0, 0);
            chki("no_done_s3", nd3, 0);
        end
    endtask

    task automatic chk_res(input string nm, input int cnt, input int fei, input bit fev, input bit ps);
        for (int d = 0; d < 2; d++) begin
            chki({nm, "_cnt"}, int'(cnt_o[d]), cnt);
            chki({nm, "_fei"}, int'(fei_o[d]), fei);
            chki({nm, "_fev"}, int'(fev_o[d]), int'(fev));
            chki({nm, "_pass"}, int'(pass_o[d]), int'(ps));
        end
    endtask

    initial begin
        for (int i = 0; i < TW; i++) g[i] = i[0] ^ i[1];
        repeat (3) @(negedge clk);
        chkv("reset_s0", 160'(actual(0)), '0);
        chkv("reset_s3", 160'(actual(1)), '0);
        rst = 1'b0;
        net_tt = g;
        exp_tt = g;
        hold_chk = 1'b1;
        sweep(40, 0, 1'b1);
        hold_chk = 1'b0;
        chk_res("pass_sweep", 0, 0, 1'b0, 1'b1);
        chkv("obs_s0", 160'(obs_o[0]), 160'(g));
        chkv("obs_s3", 160'(obs_o[1]), 160'(g));
        chki("x_hold_end", int'(x_o[0]), 127);
        e = g;
        e[5] = ~e[5];
        e[100] = ~e[100];
        exp_tt = e;
        sweep(0, 0, 1'b0);
        chk_res("inject", 2, 5, 1'b1, 1'b0);
        exp_tt = g;
        sweep(0, 60, 1'b0);
        sweep(129, 0, 1'b0);
        chk_res("after_rst", 0, 0, 1'b0, 1'b1);
        exp_tt = ~g;
        sweep(0, 0, 1'b0);
        chk_res("all_wrong", 128, 0, 1'b1, 1'b0);
        repeat (4) begin
            net_tt = {$urandom, $urandom, $urandom, $urandom};
            e = net_tt;
            repeat ($urandom_range(0, 5)) e[$urandom_range(0, TW - 1)] ^= 1'b1;
            exp_tt = e;
            sweep($urandom_range(2, 129), 0, 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
